div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider producing quotient (lo),
// remainder (hi) and a divide-by-zero flag (dz). A divide takes 32 iterations.
// Signed (two's complement) division is compiled in only when DIV_SIGNED_EN
// is defined; without it every divide is unsigned and signed_div is ignored.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              signed_div,
    input  logic              cancel,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi,
    output logic              dz
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [2*DATA_W-1:0] rq;
    logic [DATA_W-1:0]   dvs;

    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [DATA_W:0]     upper;
    logic [DATA_W:0]     trial;
    logic [2*DATA_W-1:0] next_rq;
    logic [DATA_W-1:0]   res_q;
    logic [DATA_W-1:0]   res_r;

    // One restoring step: the remainder is shifted left, then the divisor is subtracted if it fits.
    always_comb begin
        upper = rq[2*DATA_W-1:DATA_W-1];
        trial = upper - {1'b0, dvs};
        if (!trial[DATA_W]) begin
            next_rq = {trial[DATA_W-1:0], rq[DATA_W-2:0], 1'b1};
        end else begin
            next_rq = {upper[DATA_W-1:0], rq[DATA_W-2:0], 1'b0};
        end
    end

`ifdef DIV_SIGNED_EN
    logic a_neg;
    logic b_neg;
    logic neg_q;
    logic neg_r;

    // Signed requests divide magnitudes; remember the operand signs for the fix-up.
    always_comb begin
        a_neg = signed_div & dividend[DATA_W-1];
        b_neg = signed_div & divisor[DATA_W-1];
        op_a  = a_neg ? -dividend : dividend;
        op_b  = b_neg ? -divisor  : divisor;
    end

    // Quotient negated when signs differ, remainder follows the dividend's sign.
    always_comb begin
        res_q = neg_q ? -next_rq[DATA_W-1:0]        : next_rq[DATA_W-1:0];
        res_r = neg_r ? -next_rq[2*DATA_W-1:DATA_W] : next_rq[2*DATA_W-1:DATA_W];
    end

    // Capture the fix-up flags when a divide is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (!cancel && state == IDLE && start) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end
`else
    logic unused_signed_div;

    // Unsigned-only build: operands and results pass straight through.
    always_comb begin
        op_a  = dividend;
        op_b  = divisor;
        res_q = next_rq[DATA_W-1:0];
        res_r = next_rq[2*DATA_W-1:DATA_W];
    end

    assign unused_signed_div = signed_div;
`endif

    // Control FSM with registered busy/valid and result registers; cancel overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            count <= '0;
            rq    <= '0;
            dvs   <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
            lo    <= '0;
            hi    <= '0;
            dz    <= 1'b0;
        end else if (cancel) begin
            state <= IDLE;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        count <= '0;
                        if (divisor == '0) begin
                            state <= DONE;
                            valid <= 1'b1;
                            lo    <= '1;
                            hi    <= dividend;
                            dz    <= 1'b1;
                        end else begin
                            state <= CALC;
                            busy  <= 1'b1;
                            rq    <= {{DATA_W{1'b0}}, op_a};
                            dvs   <= op_b;
                        end
                    end
                end
                CALC: begin
                    rq    <= next_rq;
                    count <= count + 1'b1;
                    if (count == CNT_W'(DATA_W - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        valid <= 1'b1;
                        lo    <= res_q;
                        hi    <= res_r;
                        dz    <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Expected results come from a
// plain-arithmetic reference model and are queued at issue time; a monitor
// pops and compares whenever valid is seen. Signed cases are exercised only
// when DIV_SIGNED_EN is defined.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        valid;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dz;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .valid      (valid),
        .lo         (lo),
        .hi         (hi),
        .dz         (dz)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Reference model: ordinary integer division with truncation toward zero.
    function automatic exp_t model(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa;
        longint sb_v;
        logic   use_signed;
`ifdef DIV_SIGNED_EN
        use_signed = s;
`else
        use_signed = 1'b0 & s;
`endif
        if (b == 32'd0) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = a;
            e.dz = 1'b1;
        end else if (use_signed) begin
            sa   = longint'($signed(a));
            sb_v = longint'($signed(b));
            e.lo = 32'(sa / sb_v);
            e.hi = 32'(sa % sb_v);
            e.dz = 1'b0;
        end else begin
            e.lo = a / b;
            e.hi = a % b;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    // Single comparison with pass/fail bookkeeping.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput("lo", lo, e.lo);
                checkOutput("hi", hi, e.hi);
                checkOutput("dz", {31'd0, dz}, {31'd0, e.dz});
            end
        end
    end

    // Present a start for one edge, then scramble the operand inputs.
    task automatic issueStart(input logic s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start      = 1'b1;
        signed_div = s;
        dividend   = a;
        divisor    = b;
        @(posedge clk);
        #1;
        start      = 1'b0;
        signed_div = 1'($urandom);
        dividend   = $urandom;
        divisor    = $urandom;
    endtask

    // Queue the expected result, start the divide, and check latency and busy duration.
    task automatic applyStimulus(input logic s, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   n;
        int   busy_cycles;
        e = model(s, a, b);
        sb.push_back(e);
        issueStart(s, a, b);
        n = 0;
        busy_cycles = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (busy) busy_cycles++;
            if (valid) break;
        end
        checkOutput("latency", 32'(n), e.dz ? 32'd1 : 32'd33);
        checkOutput("busy_cycles", 32'(busy_cycles), e.dz ? 32'd0 : 32'd32);
        last_lo = e.lo;
        last_hi = e.hi;
        @(negedge clk);
    endtask

    // Cancel a divide after a given number of edges and confirm it leaves no trace.
    task automatic cancelAfter(input int edges);
        int busy_seen;
        issueStart(1'b0, 32'd100, 32'd7);
        repeat (edges - 1) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("cancel_busy", {31'd0, busy}, 32'd0);
        busy_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        checkOutput("cancel_no_restart", 32'(busy_seen), 32'd0);
        checkOutput("cancel_lo_hold", lo, last_lo);
        checkOutput("cancel_hi_hold", hi, last_hi);
    endtask

    // Main stimulus sequence.
    initial begin
        int          pulses;
        int          vi[3];
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_dz", {31'd0, dz}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        applyStimulus(1'b0, 32'd100, 32'd7);
        applyStimulus(1'b0, 32'h1234_5678, 32'd0);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 32'd5, 32'd9);
`ifdef DIV_SIGNED_EN
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd0);
`endif

        // Randomized operands, mixing full-width, small and zero divisors
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            applyStimulus(1'($urandom), a, b);
        end

        // Cancel mid-divide, at the final iteration edge, and together with start
        applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
        cancelAfter(10);
        cancelAfter(32);
        @(negedge clk);
        start = 1'b1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cancel = 1'b0;
        @(negedge clk);
        checkOutput("cancel_over_start", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 32'd9, 32'd3);

        // Asynchronous reset in the middle of a divide
        applyStimulus(1'b0, 32'd100, 32'd7);
        issueStart(1'b0, 32'd1000, 32'd3);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("async_rst_valid", {31'd0, valid}, 32'd0);
        checkOutput("async_rst_lo", lo, 32'd0);
        checkOutput("async_rst_hi", hi, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_lo = '0;
        last_hi = '0;
        applyStimulus(1'b0, 32'd100, 32'd7);

        // Start held high: one result per accepted start, restart right after DONE
        a = 32'h0BAD_F00D;
        b = 32'd13;
        e = model(1'b0, a, b);
        repeat (3) sb.push_back(e);
        pulses = 0;
        @(negedge clk);
        start = 1'b1;
        signed_div = 1'b0;
        dividend = a;
        divisor = b;
        for (int i = 0; i < 110; i++) begin
            @(posedge clk);
            #1;
            if (i == 101) start = 1'b0;
            @(negedge clk);
            if (valid) begin
                if (pulses < 3) vi[pulses] = i;
                pulses++;
            end
        end
        checkOutput("held_pulses", 32'(pulses), 32'd3);
        if (pulses >= 3) begin
            checkOutput("held_first", 32'(vi[0]), 32'd32);
            checkOutput("held_gap1", 32'(vi[1] - vi[0]), 32'd34);
            checkOutput("held_gap2", 32'(vi[2] - vi[1]), 32'd34);
        end
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
